// File: rtl/tmu2_hdiv_pkg.sv
// Shared definitions for the TMU2 horizontal divider stage.
package tmu2_hdiv_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned TEX_W   = 18;
  localparam int unsigned SPAN_W  = 17;
  localparam int unsigned SQW_W   = 11;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    OUTPUT = 2'd2
  } state_e;

endpackage

// File: rtl/tmu2_hdiv_divider17.sv
// 17-bit sequential restoring divider, one quotient bit per cycle, MSB first.
module tmu2_divider17
  import tmu2_hdiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SPAN_W-1:0] dividend,
  input  logic [SPAN_W-1:0] divisor,
  output logic [SPAN_W-1:0] quotient,
  output logic [SPAN_W-1:0] remainder,
  output logic              ready
);

  logic [SPAN_W-1:0] dividend_q, divisor_q, rem_q, quo_q;
  logic [SPAN_W-1:0] rem_d, quo_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q;
  logic [SPAN_W:0]   shifted;
  logic              ge;

  // Shift and compare run one bit wider so the incoming dividend bit never overflows.
  always_comb begin
    shifted = {rem_q, dividend_q[cnt_q]};
    ge      = shifted >= {1'b0, divisor_q};
    rem_d   = ge ? SPAN_W'(shifted - {1'b0, divisor_q}) : shifted[SPAN_W-1:0];
    quo_d   = {quo_q[SPAN_W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
    end else if (start) begin
      dividend_q <= dividend;
      divisor_q  <= divisor;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= CNT_W'(SPAN_W - 1);
      active_q   <= 1'b1;
    end else if (active_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - 1'b1;
    end
  end

  // High during the cycle whose edge performs the final step.
  assign ready     = active_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/tmu2_hdiv.sv
// TMU2 horizontal divider: divides both texture spans by the square width and
// hands quotient/remainder pairs plus pass-through coordinates downstream.
module tmu2_hdiv
  import tmu2_hdiv_pkg::*;
(
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  output logic                      busy,
  input  logic                      pipe_stb_i,
  output logic                      pipe_ack_o,
  input  logic signed [COORD_W-1:0] x,
  input  logic signed [COORD_W-1:0] y,
  input  logic signed [TEX_W-1:0]   tsx,
  input  logic signed [TEX_W-1:0]   tsy,
  input  logic                      diff_x_positive,
  input  logic                      diff_y_positive,
  input  logic [SPAN_W-1:0]         diff_x,
  input  logic [SPAN_W-1:0]         diff_y,
  input  logic [SQW_W-1:0]          dst_squarew,
  output logic                      pipe_stb_o,
  input  logic                      pipe_ack_i,
  output logic signed [COORD_W-1:0] x_f,
  output logic signed [COORD_W-1:0] y_f,
  output logic signed [TEX_W-1:0]   tsx_f,
  output logic signed [TEX_W-1:0]   tsy_f,
  output logic                      diff_x_positive_f,
  output logic                      diff_y_positive_f,
  output logic [SPAN_W-1:0]         diff_x_q,
  output logic [SPAN_W-1:0]         diff_x_r,
  output logic [SPAN_W-1:0]         diff_y_q,
  output logic [SPAN_W-1:0]         diff_y_r
);

  state_e            state_q;
  logic              start;
  logic              x_ready;
  logic              y_ready_unused;
  logic [SPAN_W-1:0] divisor;

  assign start      = (state_q == IDLE) && pipe_stb_i;
  assign divisor    = {{(SPAN_W - SQW_W){1'b0}}, dst_squarew};
  assign pipe_ack_o = (state_q == IDLE);
  assign pipe_stb_o = (state_q == OUTPUT);
  assign busy       = (state_q != IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (pipe_stb_i) begin
          x_f               <= x;
          y_f               <= y;
          tsx_f             <= tsx;
          tsy_f             <= tsy;
          diff_x_positive_f <= diff_x_positive;
          diff_y_positive_f <= diff_y_positive;
          state_q           <= DIVIDE;
        end
        DIVIDE:  if (x_ready)    state_q <= OUTPUT;
        OUTPUT:  if (pipe_ack_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Both dividers start together and take identical cycle counts.
  tmu2_divider17 u_div_x (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .start     (start),
    .dividend  (diff_x),
    .divisor   (divisor),
    .quotient  (diff_x_q),
    .remainder (diff_x_r),
    .ready     (x_ready)
  );

  tmu2_divider17 u_div_y (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .start     (start),
    .dividend  (diff_y),
    .divisor   (divisor),
    .quotient  (diff_y_q),
    .remainder (diff_y_r),
    .ready     (y_ready_unused)
  );

endmodule
